wbu_tx_arbiter: RTL and testbench
=================================

# wbu_tx_arbiter

Output-side arbiter that shares one UART transmitter between the wishbone-bus command responder and the 7-bit console port. Command bytes leave with bit 7 set and console bytes with bit 7 clear, so the host can demultiplex the two streams. The arbiter gives command traffic priority, but bounds how many consecutive command bytes may pass while the console waits. It also holds the command channel off until the host has addressed the command port. It sits between the bus-response encoder, the console source and the UART TX core.

## Interface

- `MAX_BURST`, default 16: maximum number of consecutive command bytes granted while a console byte is pending. Range 1..255.
- `CMD_PORT_OFF_UNTIL_ACCESSED`, default 1'b1: when 1, the command channel stays disabled until the first `i_rx_cmd_stb`. When 0, it is enabled from reset.
- `i_clk`, input, 1: the single clock. Everything is posedge.
- `i_reset`, input, 1: reset, asynchronous and active-high.
- `i_rx_cmd_stb`, input, 1: pulse when an RX byte with bit 7 set arrives. Arms the command channel.
- `i_cmd_stb`, input, 1: command byte valid.
- `i_cmd_data`, input, 7: command byte payload.
- `o_cmd_busy`, output, 1: command byte not accepted this cycle.
- `i_con_stb`, input, 1: console byte valid.
- `i_con_data`, input, 7: console byte payload.
- `o_con_busy`, output, 1: console byte not accepted this cycle.
- `o_tx_stb`, output, 1: byte valid to the UART.
- `o_tx_data`, output, 8: tagged byte to the UART.
- `i_tx_busy`, input, 1: the UART cannot take a byte.
- `o_cmd_active`, output, 1: the command channel is armed.

## Operation

- **Handshakes.**
  - A source byte transfers on any cycle with `stb && !busy`.
  - A UART byte transfers on any cycle with `o_tx_stb && !i_tx_busy`.
  - Sources hold their data stable while busy.
- **Holding register.** `full`, `tag` and `data` form a three-state FSM: EMPTY, HOLD_CMD, HOLD_CON.
- **Free signal.** `free = !full || !i_tx_busy`. The register can load on the same cycle it drains.
- **Arm flag.**
  - `cmd_active` resets to `!CMD_PORT_OFF_UNTIL_ACCESSED`.
  - It is set by `i_rx_cmd_stb` and never clears except on reset.
- **Starve flag.** `starve = (burst_cnt == MAX_BURST)`.
- **Grant (combinational).**
  - `take_cmd = free && cmd_active && i_cmd_stb && !(starve && i_con_stb)`.
  - `take_con = free && i_con_stb && !take_cmd`.
- **Busy outputs.**
  - `o_cmd_busy = !take_cmd`. This holds even when `i_cmd_stb` is low.
  - `o_con_busy = !take_con`.
  - Both depend combinationally on the other channel's strobe. This is intentional.
- **Load.**
  - On `take_cmd`: data ← {1, `i_cmd_data`}, tag ← CMD.
  - On `take_con`: data ← {0, `i_con_data`}, tag ← CON.
  - On drain without a new take: `full` ← 0. `data` keeps its value.
- **Burst counter.** 8-bit, saturating at `MAX_BURST`.
  - Increments on `take_cmd` when `i_con_stb` is high.
  - Clears on `take_con`, and on any cycle with `i_con_stb` low.
- **Disabled command channel.** While `!cmd_active`, command bytes are never accepted or dropped; the source simply stalls.

## Timing

- **Reset values:**
  - `o_tx_stb` = 0.
  - `o_tx_data` = 8'h00.
  - `o_cmd_active` = `!CMD_PORT_OFF_UNTIL_ACCESSED`.
  - `burst_cnt` = 0.
  - `o_cmd_busy` and `o_con_busy` follow the grant equations with `full` = 0.
- **Latency:** a byte accepted at edge N is on `o_tx_stb`/`o_tx_data` from edge N+1.
- **Throughput:** one byte per cycle while `i_tx_busy` is low. No bubble between back-to-back bytes.
- **UART stall:** while `i_tx_busy` is high and `full` is set, `o_tx_data` is stable and both busy outputs are 1.
- **Same-cycle arm:** `i_rx_cmd_stb` in the same cycle as `i_cmd_stb` does not grant the command that cycle. `cmd_active` is registered, so the grant happens next cycle.
- **Reset mid-transfer:** asynchronous reset drops `o_tx_stb` immediately and the held byte is lost. The sources retry because their strobes were never acknowledged.
- **Saturation:** at `MAX_BURST`, the next free slot goes to the console if `i_con_stb` is high. After that, `burst_cnt` is 0.
- **Console absent:** with `i_con_stb` low, the command stream is never limited.

## Structure

- Shared package `wbu_pkg`:
  - tag localparams `TAG_CMD`=1'b1 and `TAG_CON`=1'b0;
  - the 7-bit payload width constant;
  - the state encoding for EMPTY, HOLD_CMD and HOLD_CON.
- Single module, no sub-modules. The saturating counter is inline.

## Test plan

- **Disabled command channel.** After reset with `CMD_PORT_OFF_UNTIL_ACCESSED`=1, drive command 7'h41 and console 7'h30.
  - `o_cmd_busy` stays 1.
  - UART sees 8'h30 one cycle after the console accept.
  - The command byte never appears.
- **Arming.** Pulse `i_rx_cmd_stb`, then drive command 7'h55.
  - `o_cmd_active` goes 1.
  - `o_tx_data` = 8'hD5 on the cycle after accept.
- **Fairness.** `MAX_BURST`=4, both strobes held high, `i_tx_busy`=0.
  - UART tag pattern is C,C,C,C,K,C,C,C,C,K… (C = command, K = console).
  - `o_tx_stb` is high every cycle.
- **UART stall.** Hold `i_tx_busy`=1 for 5 cycles with a byte held.
  - `o_tx_data` is stable and both busy outputs are 1.
  - On release, the next pending byte appears on the following cycle with no empty cycle.
- **Reset mid-transfer.** Assert `i_reset` asynchronously (mid-cycle) while HOLD_CMD.
  - `o_tx_stb` falls before the next edge.
  - `o_tx_data` = 0 and `o_cmd_active` = 0.
- **Command port on from reset.** `CMD_PORT_OFF_UNTIL_ACCESSED`=0, drive command 7'h7F immediately after reset.
  - Accepted in the first cycle.
  - `o_tx_data` = 8'hFF.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared definitions for the wishbone-bus UART output path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: channel tag values, payload width, and holding-register states.
package wbu_pkg;

  // Bit 7 of every byte sent to the host says which stream it belongs to.
  localparam logic TAG_CMD = 1'b1;
  localparam logic TAG_CON = 1'b0;

  // Both sources deliver 7-bit payloads; the tag fills the eighth bit.
  localparam int PAYLOAD_W = 7;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_HOLD_CMD = 2'd1,
    ST_HOLD_CON = 2'd2
  } tx_state_t;

endpackage

// File: rtl/wbu_tx_arbiter.sv
// Shares one UART transmitter between the command responder and the console.
// Latency: a byte accepted at edge N is presented to the UART from edge N+1.
// Backpressure: UART busy stalls both sources; the holding register reloads on the cycle it drains.
//
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_rx_cmd_stb              host addressed the command port (arms command channel)
//   i_cmd_stb/i_cmd_data      command byte source, o_cmd_busy back-pressure
//   i_con_stb/i_con_data      console byte source, o_con_busy back-pressure
//   o_tx_stb/o_tx_data        tagged byte to UART, i_tx_busy back-pressure
//   o_cmd_active              command channel armed
module wbu_tx_arbiter
  import wbu_pkg::*;
#(
  parameter int   MAX_BURST                  = 16,
  parameter logic CMD_PORT_OFF_UNTIL_ACCESSED = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_cmd_stb,
  input  logic                 i_cmd_stb,
  input  logic [PAYLOAD_W-1:0] i_cmd_data,
  output logic                 o_cmd_busy,
  input  logic                 i_con_stb,
  input  logic [PAYLOAD_W-1:0] i_con_data,
  output logic                 o_con_busy,
  output logic                 o_tx_stb,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_cmd_active
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [7:0] r_data;
  logic [7:0] r_burst_cnt;
  logic       r_cmd_active;

  logic w_full;
  logic w_free;
  logic w_starve;
  logic w_take_cmd;
  logic w_take_con;

  assign w_full   = (r_state != ST_EMPTY);
  // The register may accept a new byte in the same cycle the UART takes the old one.
  assign w_free   = !w_full || !i_tx_busy;
  assign w_starve = (r_burst_cnt == LP_MAX_BURST);

  // Command has priority unless it has used up its burst while the console waits.
  assign w_take_cmd = w_free && r_cmd_active && i_cmd_stb && !(w_starve && i_con_stb);
  assign w_take_con = w_free && i_con_stb && !w_take_cmd;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_take_cmd) begin
      w_state_nxt = ST_HOLD_CMD;
    end else if (w_take_con) begin
      w_state_nxt = ST_HOLD_CON;
    end else if (w_full && !i_tx_busy) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Output logic
  always_comb begin
    o_tx_stb     = w_full;
    o_tx_data    = r_data;
    o_cmd_busy   = !w_take_cmd;
    o_con_busy   = !w_take_con;
    o_cmd_active = r_cmd_active;
  end

  // Payload register; retains its value after draining.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data <= 8'h00;
    end else if (w_take_cmd) begin
      r_data <= {TAG_CMD, i_cmd_data};
    end else if (w_take_con) begin
      r_data <= {TAG_CON, i_con_data};
    end
  end

  // Sticky arm flag: once the host talks to the command port it stays open.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cmd_active <= !CMD_PORT_OFF_UNTIL_ACCESSED;
    end else if (i_rx_cmd_stb) begin
      r_cmd_active <= 1'b1;
    end
  end

  // Counts command bytes granted while the console is waiting; an idle
  // console means the command stream is never throttled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_burst_cnt <= 8'd0;
    end else if (!i_con_stb || w_take_con) begin
      r_burst_cnt <= 8'd0;
    end else if (w_take_cmd && !w_starve) begin
      r_burst_cnt <= r_burst_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wbu_tx_arbiter.sv
module tb_wbu_tx_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: command port gated until accessed, short burst limit
  logic       rst, rx_cmd_stb, cmd_stb, con_stb, tx_busy;
  logic [6:0] cmd_data, con_data;
  logic       cmd_busy, con_busy, tx_stb, cmd_active;
  logic [7:0] tx_data;

  // DUT B: command port open from reset
  logic       rst_b, rx_cmd_stb_b, cmd_stb_b, con_stb_b, tx_busy_b;
  logic [6:0] cmd_data_b, con_data_b;
  logic       cmd_busy_b, con_busy_b, tx_stb_b, cmd_active_b;
  logic [7:0] tx_data_b;

  int checks   = 0;
  int failures = 0;

  wbu_tx_arbiter #(.MAX_BURST(4), .CMD_PORT_OFF_UNTIL_ACCESSED(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_cmd_stb(rx_cmd_stb),
    .i_cmd_stb(cmd_stb), .i_cmd_data(cmd_data), .o_cmd_busy(cmd_busy),
    .i_con_stb(con_stb), .i_con_data(con_data), .o_con_busy(con_busy),
    .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
    .o_cmd_active(cmd_active)
  );

  wbu_tx_arbiter #(.MAX_BURST(16), .CMD_PORT_OFF_UNTIL_ACCESSED(1'b0)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_rx_cmd_stb(rx_cmd_stb_b),
    .i_cmd_stb(cmd_stb_b), .i_cmd_data(cmd_data_b), .o_cmd_busy(cmd_busy_b),
    .i_con_stb(con_stb_b), .i_con_data(con_data_b), .o_con_busy(con_busy_b),
    .o_tx_stb(tx_stb_b), .o_tx_data(tx_data_b), .i_tx_busy(tx_busy_b),
    .o_cmd_active(cmd_active_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_cmd_stb = 1'b0; cmd_stb = 1'b0; con_stb = 1'b0; tx_busy = 1'b0;
    cmd_data = 7'h00; con_data = 7'h00;
    rst_b = 1'b1; rx_cmd_stb_b = 1'b0; cmd_stb_b = 1'b0; con_stb_b = 1'b0; tx_busy_b = 1'b0;
    cmd_data_b = 7'h00; con_data_b = 7'h00;
    step(); step();
    checks++; if (tx_stb !== 1'b0) begin failures++; $display("FAIL reset_tx_stb got=%b exp=0", tx_stb); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (cmd_active !== 1'b0) begin failures++; $display("FAIL reset_cmd_active got=%b exp=0", cmd_active); end
    checks++; if (cmd_busy !== 1'b1) begin failures++; $display("FAIL reset_cmd_busy got=%b exp=1", cmd_busy); end
    checks++; if (con_busy !== 1'b1) begin failures++; $display("FAIL reset_con_busy got=%b exp=1", con_busy); end
    checks++; if (cmd_active_b !== 1'b1) begin failures++; $display("FAIL reset_b_cmd_active got=%b exp=1", cmd_active_b); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_disabled();
    cmd_stb = 1'b1; cmd_data = 7'h41;
    con_stb = 1'b1; con_data = 7'h30;
    #1;
    checks++; if (cmd_busy !== 1'b1) begin failures++; $display("FAIL dis_cmd_busy got=%b exp=1", cmd_busy); end
    checks++; if (con_busy !== 1'b0) begin failures++; $display("FAIL dis_con_busy got=%b exp=0", con_busy); end
    step();
    checks++; if (tx_stb !== 1'b1) begin failures++; $display("FAIL dis_tx_stb got=%b exp=1", tx_stb); end
    checks++; if (tx_data !== 8'h30) begin failures++; $display("FAIL dis_tx_data got=%h exp=30", tx_data); end
    con_stb = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_busy !== 1'b1) begin failures++; $display("FAIL dis_cmd_stall[%0d] got=%b exp=1", i, cmd_busy); end
      step();
      checks++; if (tx_stb !== 1'b0) begin failures++; $display("FAIL dis_no_cmd[%0d] got=%b exp=0 data=%h", i, tx_stb, tx_data); end
    end
  endtask

  task automatic test_arm();
    cmd_data = 7'h55;
    rx_cmd_stb = 1'b1;
    #1;
    // Arming is registered: no grant in the same cycle.
    checks++; if (cmd_busy !== 1'b1) begin failures++; $display("FAIL arm_same_cycle_busy got=%b exp=1", cmd_busy); end
    step();
    rx_cmd_stb = 1'b0;
    #1;
    checks++; if (cmd_active !== 1'b1) begin failures++; $display("FAIL arm_cmd_active got=%b exp=1", cmd_active); end
    checks++; if (cmd_busy !== 1'b0) begin failures++; $display("FAIL arm_cmd_busy got=%b exp=0", cmd_busy); end
    step();
    checks++; if (tx_stb !== 1'b1) begin failures++; $display("FAIL arm_tx_stb got=%b exp=1", tx_stb); end
    checks++; if (tx_data !== 8'hD5) begin failures++; $display("FAIL arm_tx_data got=%h exp=d5", tx_data); end
    cmd_stb = 1'b0;
    step();
    checks++; if (tx_stb !== 1'b0) begin failures++; $display("FAIL arm_drain got=%b exp=0", tx_stb); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_pat [10];
    exp_pat = '{8'h91, 8'h91, 8'h91, 8'h91, 8'h22, 8'h91, 8'h91, 8'h91, 8'h91, 8'h22};
    cmd_stb = 1'b1; cmd_data = 7'h11;
    con_stb = 1'b1; con_data = 7'h22;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (tx_stb !== 1'b1) begin failures++; $display("FAIL fair_stb[%0d] got=%b exp=1", i, tx_stb); end
      checks++; if (tx_data !== exp_pat[i]) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, tx_data, exp_pat[i]); end
    end
  endtask

  task automatic test_stall();
    // Console byte 22 is held; both sources keep requesting.
    tx_busy = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (tx_data !== 8'h22 || tx_stb !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%h/%b exp=22/1", i, tx_data, tx_stb); end
      checks++; if (cmd_busy !== 1'b1 || con_busy !== 1'b1) begin failures++; $display("FAIL stall_busy[%0d] got=%b%b exp=11", i, cmd_busy, con_busy); end
      step();
    end
    tx_busy = 1'b0;
    #1;
    checks++; if (cmd_busy !== 1'b0) begin failures++; $display("FAIL stall_release_busy got=%b exp=0", cmd_busy); end
    step();
    checks++; if (tx_stb !== 1'b1 || tx_data !== 8'h91) begin failures++; $display("FAIL stall_next got=%h/%b exp=91/1", tx_data, tx_stb); end
  endtask

  task automatic test_reset_mid();
    con_stb = 1'b0;
    step();
    checks++; if (tx_stb !== 1'b1 || tx_data !== 8'h91) begin failures++; $display("FAIL rmid_pre got=%h/%b exp=91/1", tx_data, tx_stb); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx_stb !== 1'b0) begin failures++; $display("FAIL rmid_tx_stb got=%b exp=0", tx_stb); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
    checks++; if (cmd_active !== 1'b0) begin failures++; $display("FAIL rmid_cmd_active got=%b exp=0", cmd_active); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (cmd_busy !== 1'b1) begin failures++; $display("FAIL rmid_cmd_disarmed got=%b exp=1", cmd_busy); end
    cmd_stb = 1'b0;
  endtask

  task automatic test_cmd_on();
    rst_b = 1'b0;
    cmd_stb_b = 1'b1; cmd_data_b = 7'h7F;
    #1;
    checks++; if (cmd_busy_b !== 1'b0) begin failures++; $display("FAIL on_cmd_busy got=%b exp=0", cmd_busy_b); end
    step();
    checks++; if (tx_stb_b !== 1'b1 || tx_data_b !== 8'hFF) begin failures++; $display("FAIL on_tx got=%h/%b exp=ff/1", tx_data_b, tx_stb_b); end
  endtask

  task automatic test_back_to_back();
    // Console idle: 20 command bytes exceed MAX_BURST=16 without throttling.
    logic [7:0] exp_b;
    for (int i = 0; i < 20; i++) begin
      cmd_data_b = 7'(i + 8'h20);
      exp_b = {1'b1, 7'(i + 8'h20)};
      step();
      checks++; if (tx_stb_b !== 1'b1 || tx_data_b !== exp_b) begin failures++; $display("FAIL b2b[%0d] got=%h/%b exp=%h/1", i, tx_data_b, tx_stb_b, exp_b); end
    end
    cmd_stb_b = 1'b0;
    step();
    checks++; if (tx_stb_b !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", tx_stb_b); end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_arm();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_cmd_on();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
